// File: rtl/game_pkg.sv
// Shared game definitions: coordinate width, collision FSM states and side-flag bit indices.
package game_pkg;

  localparam int unsigned COORD_W = 12;

  typedef enum logic [1:0] {
    CLEAR,
    CONTACT,
    OVER
  } state_e;

  localparam int unsigned SIDE_L = 0;
  localparam int unsigned SIDE_R = 1;
  localparam int unsigned SIDE_T = 2;
  localparam int unsigned SIDE_B = 3;

endpackage

// File: rtl/rect_edge_cmp.sv
// Combinational square-vs-rectangle edge compare; one flag per side the object meets or crosses.
module rect_edge_cmp
  import game_pkg::*;
#(
  parameter int unsigned CoordW = COORD_W
) (
  input  logic [CoordW-1:0] bdr_l_i,
  input  logic [CoordW-1:0] bdr_r_i,
  input  logic [CoordW-1:0] bdr_t_i,
  input  logic [CoordW-1:0] bdr_b_i,
  input  logic [CoordW-1:0] obj_l_i,
  input  logic [CoordW-1:0] obj_r_i,
  input  logic [CoordW-1:0] obj_t_i,
  input  logic [CoordW-1:0] obj_b_i,
  output logic [3:0]        sides_o
);

  // Compares are literal; inverted object geometry is not filtered out.
  always_comb begin
    sides_o         = '0;
    sides_o[SIDE_L] = obj_l_i <= bdr_l_i;
    sides_o[SIDE_R] = obj_r_i >= bdr_r_i;
    sides_o[SIDE_T] = obj_t_i <= bdr_t_i;
    sides_o[SIDE_B] = obj_b_i >= bdr_b_i;
  end

endmodule

// File: rtl/border_collide.sv
// Border contact tracker: registers edges on each animation strobe, then reports hit episodes,
// side flags, a saturating episode count and a sticky game-over.
module border_collide #(
  parameter int unsigned COORD_W  = game_pkg::COORD_W,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned MAX_HITS = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic [COORD_W-1:0] i_bdr_l,
  input  logic [COORD_W-1:0] i_bdr_r,
  input  logic [COORD_W-1:0] i_bdr_t,
  input  logic [COORD_W-1:0] i_bdr_b,
  input  logic [COORD_W-1:0] i_obj_l,
  input  logic [COORD_W-1:0] i_obj_r,
  input  logic [COORD_W-1:0] i_obj_t,
  input  logic [COORD_W-1:0] i_obj_b,
  output logic               o_hit,
  output logic [3:0]         o_hit_side,
  output logic [COUNT_W-1:0] o_hit_count,
  output logic               o_game_over
);

  import game_pkg::*;

  logic               s1_valid_q;
  logic [COORD_W-1:0] bdr_l_q, bdr_r_q, bdr_t_q, bdr_b_q;
  logic [COORD_W-1:0] obj_l_q, obj_r_q, obj_t_q, obj_b_q;
  logic [3:0]         sides;
  logic               any_side;

  state_e             state_q, state_d;
  logic               hit_q, hit_d;
  logic [3:0]         side_q, side_d;
  logic [COUNT_W-1:0] count_q, count_d, count_inc;
  logic               over_q, over_d;
  logic               reach_max;

  rect_edge_cmp #(
    .CoordW (COORD_W)
  ) u_cmp (
    .bdr_l_i (bdr_l_q),
    .bdr_r_i (bdr_r_q),
    .bdr_t_i (bdr_t_q),
    .bdr_b_i (bdr_b_q),
    .obj_l_i (obj_l_q),
    .obj_r_i (obj_r_q),
    .obj_t_i (obj_t_q),
    .obj_b_i (obj_b_q),
    .sides_o (sides)
  );

  assign any_side  = |sides;
  assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
  assign reach_max = (MAX_HITS != 0) && (32'(count_inc) == MAX_HITS);

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    side_d  = side_q;
    count_d = count_q;
    over_d  = over_q;
    if (s1_valid_q) begin
      case (state_q)
        CLEAR: begin
          if (any_side) begin
            hit_d   = 1'b1;
            count_d = count_inc;
            side_d  = sides;
            if (reach_max) begin
              state_d = OVER;
              over_d  = 1'b1;
            end else begin
              state_d = CONTACT;
            end
          end
        end
        CONTACT: begin
          if (any_side) begin
            side_d = sides;
          end else begin
            side_d  = '0;
            state_d = CLEAR;
          end
        end
        default: ;  // OVER ignores samples until reset
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      state_q    <= CLEAR;
      hit_q      <= 1'b0;
      side_q     <= '0;
      count_q    <= '0;
      over_q     <= 1'b0;
    end else begin
      s1_valid_q <= i_ani_stb && i_animate;
      state_q    <= state_d;
      hit_q      <= hit_d;
      side_q     <= side_d;
      count_q    <= count_d;
      over_q     <= over_d;
    end
  end

  // Edge capture needs no reset: s1_valid_q gates every use of these values.
  always_ff @(posedge i_clk) begin
    if (i_ani_stb && i_animate) begin
      bdr_l_q <= i_bdr_l;
      bdr_r_q <= i_bdr_r;
      bdr_t_q <= i_bdr_t;
      bdr_b_q <= i_bdr_b;
      obj_l_q <= i_obj_l;
      obj_r_q <= i_obj_r;
      obj_t_q <= i_obj_t;
      obj_b_q <= i_obj_b;
    end
  end

  assign o_hit       = hit_q;
  assign o_hit_side  = side_q;
  assign o_hit_count = count_q;
  assign o_game_over = over_q;

endmodule

// File: tb/tb_border_collide.sv
// Bench for border_collide: two configurations share one stimulus stream and are checked every
// cycle against an episode-level model, with literal checkpoints at key moments.
module tb_border_collide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        animate = 1'b1;
  logic [11:0] bdr_l = 12'd40, bdr_r = 12'd600, bdr_t = 12'd40, bdr_b = 12'd440;
  logic [11:0] obj_l = 12'd100, obj_r = 12'd140, obj_t = 12'd100, obj_b = 12'd140;

  logic       hit_a, over_a, hit_b, over_b;
  logic [3:0] side_a, side_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  int tests = 0;
  int fails = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  border_collide #(.COORD_W(12), .COUNT_W(8), .MAX_HITS(3)) dut_a (
    .i_clk (clk), .i_rst (rst), .i_ani_stb (stb), .i_animate (animate),
    .i_bdr_l (bdr_l), .i_bdr_r (bdr_r), .i_bdr_t (bdr_t), .i_bdr_b (bdr_b),
    .i_obj_l (obj_l), .i_obj_r (obj_r), .i_obj_t (obj_t), .i_obj_b (obj_b),
    .o_hit (hit_a), .o_hit_side (side_a), .o_hit_count (count_a), .o_game_over (over_a)
  );

  border_collide #(.COORD_W(12), .COUNT_W(2), .MAX_HITS(0)) dut_b (
    .i_clk (clk), .i_rst (rst), .i_ani_stb (stb), .i_animate (animate),
    .i_bdr_l (bdr_l), .i_bdr_r (bdr_r), .i_bdr_t (bdr_t), .i_bdr_b (bdr_b),
    .i_obj_l (obj_l), .i_obj_r (obj_r), .i_obj_t (obj_t), .i_obj_b (obj_b),
    .o_hit (hit_b), .o_hit_side (side_b), .o_hit_count (count_b), .o_game_over (over_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Episode model: index 0 = (COUNT_W 8, MAX_HITS 3), index 1 = (COUNT_W 2, MAX_HITS 0).
  int         cap[2]  = '{255, 3};
  int         maxh[2] = '{3, 0};
  bit         m_pend = 1'b0;
  logic [3:0] m_pend_side = '0;
  bit         m_contact[2] = '{0, 0};
  bit         m_over[2]    = '{0, 0};
  bit         m_hit[2]     = '{0, 0};
  logic [3:0] m_side[2]    = '{4'd0, 4'd0};
  int         m_count[2]   = '{0, 0};

  task automatic model_step();
    if (rst) begin
      m_pend = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_contact[k] = 1'b0; m_over[k] = 1'b0; m_hit[k] = 1'b0;
        m_side[k] = '0; m_count[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_hit[k] = 1'b0;
        if (m_pend && !m_over[k]) begin
          if (m_pend_side != 0) begin
            if (!m_contact[k]) begin
              m_hit[k] = 1'b1;
              m_count[k] = (m_count[k] + 1 > cap[k]) ? cap[k] : m_count[k] + 1;
              if (maxh[k] != 0 && m_count[k] == maxh[k]) m_over[k] = 1'b1;
            end
            if (!m_contact[k] || m_contact[k]) m_side[k] = m_pend_side;
            m_contact[k] = 1'b1;
          end else begin
            m_contact[k] = 1'b0;
            m_side[k] = '0;
          end
        end
      end
      m_pend = stb && animate;
      m_pend_side = {obj_b >= bdr_b, obj_t <= bdr_t, obj_r >= bdr_r, obj_l <= bdr_l};
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (compare_on) begin
      check("a.hit", 32'(hit_a), 32'(m_hit[0]));
      check("a.side", 32'(side_a), 32'(m_side[0]));
      check("a.count", 32'(count_a), m_count[0]);
      check("a.over", 32'(over_a), 32'(m_over[0]));
      check("b.hit", 32'(hit_b), 32'(m_hit[1]));
      check("b.side", 32'(side_b), 32'(m_side[1]));
      check("b.count", 32'(count_b), m_count[1]);
      check("b.over", 32'(over_b), 32'(m_over[1]));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single strobe; returns just after the edge where the sample's outputs appear.
  task automatic strobe_once();
    stb = 1'b1;
    cyc();
    stb = 1'b0;
    cyc();
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    compare_on = 1'b1;
    check("reset count", 32'(count_a), 0);
    check("reset side", 32'(side_a), 0);
    check("reset over", 32'(over_a), 0);

    // 1: idle strobes, back-to-back
    stb = 1'b1;
    cyc(4);
    stb = 1'b0;
    cyc(2);
    check("idle count", 32'(count_a), 0);

    // 2: left contact, pulse two edges after the strobe
    obj_l = 12'd40;
    stb = 1'b1;
    cyc();
    stb = 1'b0;
    check("hit not early", 32'(hit_a), 0);
    cyc();
    check("hit pulse", 32'(hit_a), 1);
    check("hit side L", 32'(side_a), 32'h1);
    check("hit count 1", 32'(count_a), 1);
    cyc();
    check("hit one cycle", 32'(hit_a), 0);

    // 3: held contact, side follows, then clear, then second episode
    strobe_once();
    strobe_once();
    obj_l = 12'd100; obj_r = 12'd600;
    strobe_once();
    strobe_once();
    strobe_once();
    check("side R", 32'(side_a), 32'h2);
    check("count held", 32'(count_a), 1);
    obj_r = 12'd140;
    strobe_once();
    check("side clear", 32'(side_a), 0);
    obj_t = 12'd40;
    strobe_once();
    check("count 2", 32'(count_a), 2);
    check("side T", 32'(side_a), 32'h4);

    // 4: third episode ends the game
    obj_t = 12'd100;
    strobe_once();
    obj_b = 12'd440;
    strobe_once();
    check("over hit", 32'(hit_a), 1);
    check("over flag", 32'(over_a), 1);
    check("over count", 32'(count_a), 3);
    obj_b = 12'd140;
    strobe_once();
    obj_l = 12'd40;
    strobe_once();
    check("frozen hit", 32'(hit_a), 0);
    check("frozen side", 32'(side_a), 32'h8);
    check("frozen count", 32'(count_a), 3);
    check("b count 3", 32'(count_b), 3);
    check("b no over", 32'(over_b), 0);

    // 5: animate low ignored; reset discards a sample in flight
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    animate = 1'b0;
    strobe_once();
    cyc();
    check("anim off count", 32'(count_a), 0);
    animate = 1'b1;
    stb = 1'b1;
    cyc();
    stb = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("flight hit", 32'(hit_a), 0);
    check("flight count", 32'(count_a), 0);
    cyc(2);

    // 6: five back-to-back episodes; narrow counter saturates
    stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      obj_l = 12'd40;
      cyc();
      obj_l = 12'd100;
      cyc();
    end
    stb = 1'b0;
    cyc(3);
    check("b sat count", 32'(count_b), 3);
    check("b sat over", 32'(over_b), 0);
    check("a over again", 32'(over_a), 1);

    compare_on = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
